// File: rtl/inst_fetch_resp.sv
// In-order fetch responder: accepted PCs wait in a small queue for a fixed access
// latency, then the head word is presented to the decoder from a preloadable array.
`ifndef AddrWidth
`define AddrWidth 32
`endif
`ifndef InstWidth
`define InstWidth 32
`endif

module inst_fetch_resp #(
    parameter int ADDR    = `AddrWidth,
    parameter int INST    = `InstWidth,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2,
    parameter int QDEPTH  = 4
) (
    input  logic            clk,
    input  logic            reset_,
    input  logic            pc_e_,
    input  logic [ADDR-1:0] pc,
    output logic            pc_stall,
    input  logic            flush_,
    input  logic            dec_stall,
    output logic            inst_e_,
    output logic [INST-1:0] inst,
    output logic [ADDR-1:0] inst_pc,
    output logic            misalign,
    input  logic            ld_e_,
    input  logic [ADDR-1:0] ld_addr,
    input  logic [INST-1:0] ld_data
);

    localparam int IW = $clog2(DEPTH);
    localparam int QW = $clog2(QDEPTH);
    localparam int CW = 2;

    localparam logic [CW-1:0]   CNT_INIT = CW'(LATENCY - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [QW:0]     PTR_ONE  = (QW+1)'(1);
    localparam logic [INST-1:0] NOP      = INST'(32'h0000_0013);

    logic [ADDR-1:0] qpc_q [QDEPTH];
    logic [ADDR-1:0] qpc_d [QDEPTH];
    logic [CW-1:0]   cnt_q [QDEPTH];
    logic [CW-1:0]   cnt_d [QDEPTH];
    logic [QW:0]     wr_ptr_q, wr_ptr_d;
    logic [QW:0]     rd_ptr_q, rd_ptr_d;
    logic [INST-1:0] mem_q [DEPTH];

    logic [QW-1:0]   wr_idx, rd_idx;
    logic            q_empty, q_full;
    logic            head_ready, push, pop, present;
    logic [ADDR-1:0] head_pc;
    logic [IW-1:0]   head_word;
    logic            head_mis;
    logic            unused_ld_bits;

    assign wr_idx = wr_ptr_q[QW-1:0];
    assign rd_idx = rd_ptr_q[QW-1:0];

    // Only the word-index bits of the load address select an array entry.
    assign unused_ld_bits = ^{ld_addr[ADDR-1:IW+2], ld_addr[1:0]};

    always_comb begin
        q_empty    = (wr_ptr_q == rd_ptr_q);
        q_full     = (wr_ptr_q[QW] != rd_ptr_q[QW]) && (wr_idx == rd_idx);
        head_ready = !q_empty && (cnt_q[rd_idx] == '0);
        push       = !pc_e_ && !q_full && flush_;
        pop        = head_ready && !dec_stall && flush_;
    end

    assign pc_stall = q_full;

    // Countdowns run on every slot regardless of head stall; stale slots are
    // harmless because a push always reloads the slot it writes.
    always_comb begin
        qpc_d    = qpc_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        for (int i = 0; i < QDEPTH; i++) begin
            if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
        end
        if (!flush_) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push) begin
                qpc_d[wr_idx] = pc;
                cnt_d[wr_idx] = CNT_INIT;
                wr_ptr_d      = wr_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                qpc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            qpc_q    <= qpc_d;
            cnt_q    <= cnt_d;
        end
    end

    // The instruction array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!ld_e_) begin
            mem_q[ld_addr[IW+1:2]] <= ld_data;
        end
    end

    always_comb begin
        head_pc   = qpc_q[rd_idx];
        head_word = head_pc[IW+1:2];
        head_mis  = (head_pc[1:0] != 2'b00);
        present   = head_ready && flush_;
        inst_e_   = !present;
        inst      = '0;
        inst_pc   = '0;
        misalign  = 1'b0;
        if (present) begin
            inst_pc  = head_pc;
            misalign = head_mis;
            inst     = head_mis ? NOP : mem_q[head_word];
        end
    end

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Bench for inst_fetch_resp: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based reference model.
module tb_inst_fetch_resp;

    localparam int ADDR    = 32;
    localparam int INST    = 32;
    localparam int DEPTH   = 1024;
    localparam int LATENCY = 2;
    localparam int QDEPTH  = 4;
    localparam int NPRE    = 64;

    logic        clk = 1'b0;
    logic        reset_;
    logic        pc_e_;
    logic [31:0] pc;
    logic        pc_stall;
    logic        flush_;
    logic        dec_stall;
    logic        inst_e_;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        misalign;
    logic        ld_e_;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;

    int checks = 0;
    int errors = 0;
    int respCount = 0;
    logic checkEn = 1'b0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] t;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mmem [DEPTH];
    logic [31:0] cyc = 0;
    logic        mFull, mReady;
    logic        eReady, eMis, eStall;
    logic [31:0] ePc, eInst;

    int          k, respStart;
    logic        acc;
    logic [31:0] p;

    inst_fetch_resp #(
        .ADDR(ADDR), .INST(INST), .DEPTH(DEPTH), .LATENCY(LATENCY), .QDEPTH(QDEPTH)
    ) dut (
        .clk(clk), .reset_(reset_), .pc_e_(pc_e_), .pc(pc), .pc_stall(pc_stall),
        .flush_(flush_), .dec_stall(dec_stall), .inst_e_(inst_e_), .inst(inst),
        .inst_pc(inst_pc), .misalign(misalign), .ld_e_(ld_e_), .ld_addr(ld_addr),
        .ld_data(ld_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic pe, input logic [31:0] pa, input logic fl, input logic ds);
        pc_e_     = pe;
        pc        = pa;
        flush_    = fl;
        dec_stall = ds;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: an entry accepted at edge t becomes presentable once the
    // edge count reaches t + LATENCY - 1; the oldest entry is always served first.
    always @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            mq.delete();
        end else begin
            mFull  = (mq.size() == QDEPTH);
            mReady = (mq.size() > 0) && (cyc >= mq[0].t + LATENCY - 1);
            if (!flush_) begin
                mq.delete();
            end else begin
                if (mReady && !dec_stall) void'(mq.pop_front());
                if (!pc_e_ && !mFull) mq.push_back('{pc: pc, t: cyc + 1});
            end
            cyc = cyc + 1;
        end
    end

    always @(posedge clk) begin
        if (!ld_e_) mmem[ld_addr[11:2]] = ld_data;
    end

    always @(negedge clk) begin
        if (checkEn) begin
            eReady = reset_ && flush_ && (mq.size() > 0) && (cyc >= mq[0].t + LATENCY - 1);
            ePc    = 32'h0;
            eMis   = 1'b0;
            eInst  = 32'h0;
            if (eReady) begin
                ePc   = mq[0].pc;
                eMis  = (ePc[1:0] != 2'b00);
                eInst = eMis ? 32'h0000_0013 : mmem[ePc[11:2]];
            end
            eStall = reset_ && (mq.size() == QDEPTH);
            checkOutput("cmp_inst_e_", inst_e_, !eReady);
            checkOutput("cmp_inst", inst, eInst);
            checkOutput("cmp_inst_pc", inst_pc, ePc);
            checkOutput("cmp_misalign", misalign, eMis);
            checkOutput("cmp_pc_stall", pc_stall, eStall);
            if (!inst_e_ && !dec_stall && flush_) respCount++;
        end
    end

    initial begin
        reset_ = 1'b0;
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0);
        ld_e_ = 1'b1; ld_addr = 32'h0; ld_data = 32'h0;
        #1 checkEn = 1'b1;
        #2;
        checkOutput("rst_inst_e_", inst_e_, 1);
        checkOutput("rst_inst", inst, 0);
        checkOutput("rst_inst_pc", inst_pc, 0);
        checkOutput("rst_misalign", misalign, 0);
        checkOutput("rst_pc_stall", pc_stall, 0);
        tick(); tick();
        reset_ = 1'b1;

        for (int i = 0; i < NPRE; i++) begin
            ld_e_   = 1'b0;
            ld_addr = i * 4;
            ld_data = (i < 8) ? 32'h1000 + i : $urandom;
            tick();
        end
        ld_e_ = 1'b1;
        #2 checkOutput("idle_inst_e_", inst_e_, 1);
        tick();

        // Single request, LATENCY=2.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0); tick();
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0);
        #2 checkOutput("lat_wait", inst_e_, 1); tick();
        #2;
        checkOutput("lat_valid", inst_e_, 0);
        checkOutput("lat_inst", inst, 32'h1000);
        checkOutput("lat_inst_pc", inst_pc, 32'h0);
        tick();
        #2 checkOutput("lat_popped", inst_e_, 1); tick();

        // Back-to-back requests, no bubbles.
        for (int j = 0; j < 6; j++) begin
            if (j < 4) applyStimulus(1'b0, j * 4, 1'b1, 1'b0);
            else       applyStimulus(1'b1, 32'h0, 1'b1, 1'b0);
            #2;
            checkOutput("b2b_pc_stall", pc_stall, 0);
            if (j >= 2) begin
                checkOutput("b2b_valid", inst_e_, 0);
                checkOutput("b2b_inst", inst, 32'h1000 + j - 2);
            end
            tick();
        end

        // Decoder stall fills the queue; requester holds until accepted.
        k = 0;
        respStart = respCount;
        for (int c = 0; c < 40 && k < 6; c++) begin
            applyStimulus(1'b0, 32'h20 + k * 4, 1'b1, c < 12);
            #2;
            if (c == 3) checkOutput("full_not_yet", pc_stall, 0);
            if (c == 4 || c == 8) checkOutput("full_stall", pc_stall, 1);
            acc = !pc_stall;
            tick();
            if (acc) k++;
        end
        checkOutput("full_all_issued", k, 6);
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0);
        repeat (10) tick();
        checkOutput("full_resp_count", respCount - respStart, 6);

        // Flush with three outstanding and a request in the same cycle.
        for (int j = 0; j < 3; j++) begin
            applyStimulus(1'b0, 32'h30 + j * 4, 1'b1, 1'b1); tick();
        end
        applyStimulus(1'b0, 32'h40, 1'b0, 1'b1);
        #2 checkOutput("flush_cycle", inst_e_, 1); tick();
        for (int j = 0; j < 3; j++) begin
            applyStimulus(1'b1, 32'h0, 1'b1, 1'b0);
            #2 checkOutput("flush_after", inst_e_, 1); tick();
        end
        applyStimulus(1'b0, 32'h10, 1'b1, 1'b0); tick();
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0);
        #2 checkOutput("flush_next_wait", inst_e_, 1); tick();
        #2;
        checkOutput("flush_next_valid", inst_e_, 0);
        checkOutput("flush_next_inst", inst, 32'h1004);
        checkOutput("flush_next_pc", inst_pc, 32'h10);
        tick();

        // Misaligned PC and address wrap-around.
        applyStimulus(1'b0, 32'h2, 1'b1, 1'b0); tick();
        applyStimulus(1'b0, DEPTH * 4 + 4, 1'b1, 1'b0); tick();
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0);
        #2;
        checkOutput("mis_valid", inst_e_, 0);
        checkOutput("mis_flag", misalign, 1);
        checkOutput("mis_nop", inst, 32'h13);
        checkOutput("mis_pc", inst_pc, 32'h2);
        tick();
        #2;
        checkOutput("wrap_valid", inst_e_, 0);
        checkOutput("wrap_flag", misalign, 0);
        checkOutput("wrap_inst", inst, 32'h1001);
        checkOutput("wrap_pc", inst_pc, DEPTH * 4 + 4);
        tick();

        // Reset while two entries are outstanding.
        applyStimulus(1'b0, 32'h8, 1'b1, 1'b1); tick();
        applyStimulus(1'b0, 32'hC, 1'b1, 1'b1); tick();
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b1);
        #1 checkOutput("prerst_valid", inst_e_, 0);
        reset_ = 1'b0;
        #1;
        checkOutput("midrst_inst_e_", inst_e_, 1);
        checkOutput("midrst_inst", inst, 0);
        checkOutput("midrst_inst_pc", inst_pc, 0);
        checkOutput("midrst_pc_stall", pc_stall, 0);
        tick(); tick();
        reset_ = 1'b1;
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0);
        for (int j = 0; j < 4; j++) begin
            #2 checkOutput("postrst_idle", inst_e_, 1); tick();
        end

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            p = $urandom_range(0, NPRE - 1) * 4;
            if ($urandom_range(0, 15) == 0) p[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0)  p[31:12] = 20'($urandom);
            applyStimulus($urandom_range(0, 3) == 0, p,
                          !($urandom_range(0, 29) == 0), $urandom_range(0, 3) == 0);
            ld_e_   = !($urandom_range(0, 9) == 0);
            ld_addr = $urandom_range(0, NPRE - 1) * 4;
            ld_data = $urandom;
            tick();
        end

        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0);
        ld_e_ = 1'b1;
        repeat (8) tick();
        checkEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_resp.md
# inst_fetch_resp

Instruction-side responder for the fetch stage: accepts fetch PCs from the front end, holds them in an in-order outstanding-request queue with a programmable access latency, and returns the instruction word with its PC to the decoder. It sits at the memory end of the PC/instruction interface and serves as both the L1 I-cache stand-in for CPU-level simulation and the base for the real I-cache response path. A bench-side load port preloads the instruction array.

## Interface
Parameters:
- ADDR, `AddrWidth, address width
- INST, `InstWidth, instruction width
- DEPTH, 1024, instruction array size in words (power of two)
- LATENCY, 2, cycles from request acceptance to response valid (legal 1..4)
- QDEPTH, 4, maximum outstanding requests (power of two, >= 2)

Ports (reset is asynchronous, active-low; one clock):
- clk  in  1  system clock
- reset_  in  1  asynchronous active-low reset
- pc_e_  in  1  fetch request valid, active-low
- pc  in  ADDR  fetch address
- pc_stall  out  1  request not accepted this cycle (queue full)
- flush_  in  1  active-low; discard all outstanding requests
- dec_stall  in  1  decoder cannot take the presented instruction
- inst_e_  out  1  instruction valid, active-low
- inst  out  INST  instruction word
- inst_pc  out  ADDR  PC of presented instruction
- misalign  out  1  presented request had pc[1:0] != 0
- ld_e_  in  1  array write enable, active-low
- ld_addr  in  ADDR  byte address of array write
- ld_data  in  INST  array write data

## Operation
- Queue: circular buffer of QDEPTH entries {pc, countdown}; read/write pointers one bit wider than log2(QDEPTH) for full/empty.
- Accept: pc_e_ low, pc_stall low, flush_ high -> push {pc, LATENCY-1} at the clock edge.
- pc_stall = queue full; asserts when full even if a pop occurs the same cycle (no push-on-pop when full).
- Countdown: every valid entry with countdown > 0 decrements each cycle, independent of head stall.
- Head ready = queue not empty and head countdown == 0. inst_e_ is low when head ready and flush_ high.
- Pop: head ready and dec_stall low and flush_ high. While dec_stall is high, outputs hold unchanged.
- Data: word index = pc[log2(DEPTH)+1:2]; upper bits ignored (wrap-around modulo DEPTH words). inst read combinationally from the array at the head PC.
- Misaligned pc: inst = 32'h0000_0013 (NOP), misalign = 1; the entry otherwise behaves normally.
- Flush: flush_ low clears the queue at the edge (pointers equal, empty); a request presented in the same cycle is dropped; inst_e_ forced Disable_ during the flush cycle.
- Load port: ld_e_ low writes ld_data to word ld_addr[log2(DEPTH)+1:2] at the edge; a head entry reading that word sees new data from the next cycle. Array contents are not reset.
- When inst_e_ is high, inst, inst_pc and misalign are 0.

## Timing
- Reset values: inst_e_ = 1 (Disable_), inst = 0, inst_pc = 0, misalign = 0, pc_stall = 0, queue empty. Reset asserted mid-operation discards all entries immediately.
- Latency: request accepted at edge T -> inst_e_ low in the cycle after edge T+LATENCY-1 (LATENCY=1: the cycle right after acceptance).
- Throughput: one request accepted and one response returned per cycle in steady state when QDEPTH >= LATENCY+1.
- Responses strictly in request order.
- With dec_stall held, entries queue up to QDEPTH, then pc_stall asserts in the cycle after the edge that fills the queue.
- Flush and dec_stall together: flush wins.

## Test plan
- Reset then idle: all outputs at reset values; preload words 0..7 = 0x1000+i; request pc 0x0 at cycle 1, LATENCY=2 -> inst_e_ low two cycles later with inst 0x1000, inst_pc 0x0.
- Back-to-back pcs 0x0,0x4,0x8,0xC -> four consecutive valid responses 0x1000..0x1003 in order, no bubbles, pc_stall never high.
- Hold dec_stall high while issuing 6 requests with QDEPTH=4 -> pc_stall high after 4th accept, 5th/6th held by requester; release -> 4 responses then remaining 2, none lost or duplicated.
- Flush with 3 outstanding and a new request in the same cycle -> inst_e_ high that cycle and after; no stale response; next request pc 0x10 returns 0x1004 after LATENCY.
- pc 0x2 -> response with misalign = 1, inst = 0x00000013; pc = DEPTH*4 + 0x4 -> returns word 1 (0x1001).
- Reset asserted while 2 entries outstanding -> outputs return to reset values immediately; no response after reset deasserts.
